sreg_seq: RTL

Access sequencer for the eight-entry 16-bit scalar register file. It is the initiator side of that file's RD/WR/WR_l/WR_h/Addr/DataIn/DataOut interface. It accepts one command at a time from the decode stage (load low/high byte, full write, read, move, clear-all) and drives the register-file strobes with the required hold and read-latency timing. Completion is reported with a one-cycle Done pulse.

---
 rtl/sreg_seq_if.sv | 40 ++++
 rtl/sreg_seq.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/sreg_seq_if.sv
// rtl/sreg_seq_if.sv - command and register-file signal bundle for sreg_seq
//
// Purpose: groups the decode-stage command handshake and the scalar
// register-file access lines into one bundle.
// master modport: the sequencer (drives strobes, Addr, RegDataOut, status).
// slave modport : the environment (decode stage plus register file).
//   Start/Op/Dst/Src/Imm  command request and operands
//   RegDataIn             register-file read data
//   Addr/RegDataOut       register-file address and write data
//   RD/WR/WR_l/WR_h       register-file strobes
//   Busy/Done/Err/Result  command status and read result

interface sreg_seq_if;
   logic        Start;
   logic [2:0]  Op;
   logic [2:0]  Dst;
   logic [2:0]  Src;
   logic [15:0] Imm;
   logic [15:0] RegDataIn;
   logic [2:0]  Addr;
   logic [15:0] RegDataOut;
   logic        RD;
   logic        WR;
   logic        WR_l;
   logic        WR_h;
   logic        Busy;
   logic        Done;
   logic        Err;
   logic [15:0] Result;

   modport master (
      input  Start, Op, Dst, Src, Imm, RegDataIn,
      output Addr, RegDataOut, RD, WR, WR_l, WR_h, Busy, Done, Err, Result
   );

   modport slave (
      output Start, Op, Dst, Src, Imm, RegDataIn,
      input  Addr, RegDataOut, RD, WR, WR_l, WR_h, Busy, Done, Err, Result
   );
endinterface

// File: rtl/sreg_seq.sv
// rtl/sreg_seq.sv - access sequencer for the 8x16 scalar register file
//
// Purpose: accepts one command at a time (NOP, LLB, LHB, WRF, RDR, MOV,
// CLR, reserved) and drives the register-file strobes with WR_HOLD-cycle
// write windows and RD_LAT-cycle read windows, ending each command with a
// one-cycle Done pulse.
// Ports:
//   Clk    single clock, posedge
//   Rst_n  synchronous active-low reset
//   bus    sreg_seq_if.master (command handshake + register-file lines)

module sreg_seq #(
   parameter int WR_HOLD = 2,
   parameter int RD_LAT  = 2
) (
   input logic        Clk,
   input logic        Rst_n,
   sreg_seq_if.master bus
);
   localparam logic [2:0] OP_LLB = 3'd1;
   localparam logic [2:0] OP_LHB = 3'd2;
   localparam logic [2:0] OP_WRF = 3'd3;
   localparam logic [2:0] OP_RDR = 3'd4;
   localparam logic [2:0] OP_MOV = 3'd5;
   localparam logic [2:0] OP_CLR = 3'd6;
   localparam logic [2:0] OP_RSV = 3'd7;

   typedef enum logic [2:0] {IDLE, WRITE, RD_WAIT, WR_BACK, CLR, FIN} state_t;

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  idx_q, idx_d;
   logic [2:0]  op_q, op_d;
   logic [2:0]  dst_q, dst_d;
   logic [2:0]  addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic [15:0] result_q, result_d;
   logic        wr_last, rd_last;

   assign wr_last = (cnt_q == 16'(WR_HOLD - 1));
   assign rd_last = (cnt_q == 16'(RD_LAT - 1));

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         op_q     <= '0;
         dst_q    <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         op_q     <= op_d;
         dst_q    <= dst_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         result_q <= result_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      op_d     = op_q;
      dst_d    = dst_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      result_d = result_q;
      case (state_q)
         // FIN also accepts, so a held Start is taken on the edge ending FIN.
         IDLE, FIN: begin
            state_d = IDLE;
            if (bus.Start) begin
               op_d  = bus.Op;
               dst_d = bus.Dst;
               cnt_d = '0;
               idx_d = '0;
               case (bus.Op)
                  OP_LLB: begin
                     state_d = WRITE;
                     addr_d  = bus.Dst;
                     wdata_d = {8'h00, bus.Imm[7:0]};
                  end
                  OP_LHB: begin
                     state_d = WRITE;
                     addr_d  = bus.Dst;
                     wdata_d = {bus.Imm[7:0], 8'h00};
                  end
                  OP_WRF: begin
                     state_d = WRITE;
                     addr_d  = bus.Dst;
                     wdata_d = bus.Imm;
                  end
                  OP_RDR: begin
                     state_d = RD_WAIT;
                     addr_d  = bus.Dst;
                  end
                  OP_MOV: begin
                     state_d = RD_WAIT;
                     addr_d  = bus.Src;
                  end
                  OP_CLR: begin
                     state_d = CLR;
                     addr_d  = '0;
                     wdata_d = '0;
                  end
                  default: state_d = FIN;
               endcase
            end
         end
         WRITE, WR_BACK: begin
            if (wr_last) begin
               state_d = FIN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         RD_WAIT: begin
            if (rd_last) begin
               cnt_d    = '0;
               result_d = bus.RegDataIn;
               if (op_q == OP_MOV) begin
                  // Write-back data comes straight from the read bus so WR
                  // can rise in the cycle right after RD drops.
                  state_d = WR_BACK;
                  addr_d  = dst_q;
                  wdata_d = bus.RegDataIn;
               end else begin
                  state_d = FIN;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         CLR: begin
            if (wr_last) begin
               cnt_d = '0;
               idx_d = idx_q + 3'd1;
               // Addr keeps index 7 after the sweep rather than wrapping.
               if (idx_q == 3'd7) begin
                  state_d = FIN;
               end else begin
                  addr_d = idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.Addr       = addr_q;
   assign bus.RegDataOut = wdata_q;
   assign bus.RD         = (state_q == RD_WAIT);
   assign bus.WR         = (state_q == WR_BACK) || (state_q == CLR) ||
                           ((state_q == WRITE) && (op_q == OP_WRF));
   assign bus.WR_l       = (state_q == WRITE) && (op_q == OP_LLB);
   assign bus.WR_h       = (state_q == WRITE) && (op_q == OP_LHB);
   assign bus.Busy       = (state_q != IDLE) && (state_q != FIN);
   assign bus.Done       = (state_q == FIN);
   assign bus.Err        = (state_q == FIN) && (op_q == OP_RSV);
   assign bus.Result     = result_q;
endmodule
